// File: rtl/hd6309_clkgen.sv
// E/Q quadrature bus-clock generator and core reset sequencer for the HD6309.
// Divides CLK4 into four quarters of QUARTER cycles, with MRDY stretching of the E-high phase.
module hd6309_clkgen #(
    parameter int QUARTER     = 1,
    parameter int RST_CYCLES  = 1,
    parameter int MAX_STRETCH = 8
) (
    input  logic       CLK4,
    input  logic       nRESET,
    input  logic       MRDY,
    output logic       E,
    output logic       Q,
    output logic [1:0] PHASE,
    output logic       E_RISE,
    output logic       E_FALL,
    output logic       STRETCH,
    output logic       CORE_nRESET
);

    localparam int PW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam int SW = (MAX_STRETCH > 0) ? $clog2(MAX_STRETCH + 1) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

    localparam logic [PW-1:0] PLAST = PW'(QUARTER - 1);
    localparam logic [SW-1:0] SMAX  = SW'(MAX_STRETCH);
    localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        PH_E_HI_Q_LO = 2'd0,
        PH_E_HI_Q_HI = 2'd1,
        PH_E_LO_Q_HI = 2'd2,
        PH_E_LO_Q_LO = 2'd3
    } phase_t;

    logic [PW-1:0] pcnt, pcntNext;
    logic [SW-1:0] scnt, scntNext;
    logic [RW-1:0] rcnt, rcntNext;
    phase_t        phase, phaseNext;
    logic          eNext, qNext;
    logic          eRiseNext, eFallNext, stretchNext, coreNext;
    logic          tick;

    assign tick = (pcnt == PLAST);

    always_comb begin
        pcntNext    = tick ? '0 : pcnt + 1'b1;
        phaseNext   = phase;
        scntNext    = scnt;
        rcntNext    = rcnt;
        stretchNext = STRETCH;
        coreNext    = CORE_nRESET;
        eRiseNext   = 1'b0;
        eFallNext   = 1'b0;
        if (tick) begin
            stretchNext = 1'b0;
            unique case (phase)
                PH_E_HI_Q_LO: phaseNext = PH_E_HI_Q_HI;
                PH_E_HI_Q_HI: begin
                    // MRDY only matters at the tick that would end the Q-high quarter.
                    if (!MRDY && (scnt < SMAX)) begin
                        scntNext    = scnt + 1'b1;
                        stretchNext = 1'b1;
                    end else begin
                        phaseNext = PH_E_LO_Q_HI;
                        scntNext  = '0;
                        eFallNext = 1'b1;
                    end
                end
                PH_E_LO_Q_HI: begin
                    phaseNext = PH_E_LO_Q_LO;
                    if (!CORE_nRESET) begin
                        if (rcnt == RLAST) coreNext = 1'b1;
                        else               rcntNext = rcnt + 1'b1;
                    end
                end
                PH_E_LO_Q_LO: begin
                    phaseNext = PH_E_HI_Q_LO;
                    eRiseNext = 1'b1;
                end
                default: phaseNext = PH_E_LO_Q_LO;
            endcase
        end
        eNext = (phaseNext == PH_E_HI_Q_LO) || (phaseNext == PH_E_HI_Q_HI);
        qNext = (phaseNext == PH_E_HI_Q_HI) || (phaseNext == PH_E_LO_Q_HI);
    end

    always_ff @(posedge CLK4) begin
        if (!nRESET) begin
            pcnt        <= '0;
            phase       <= PH_E_LO_Q_LO;
            scnt        <= '0;
            rcnt        <= '0;
            E           <= 1'b0;
            Q           <= 1'b0;
            E_RISE      <= 1'b0;
            E_FALL      <= 1'b0;
            STRETCH     <= 1'b0;
            CORE_nRESET <= 1'b0;
        end else begin
            pcnt        <= pcntNext;
            phase       <= phaseNext;
            scnt        <= scntNext;
            rcnt        <= rcntNext;
            E           <= eNext;
            Q           <= qNext;
            E_RISE      <= eRiseNext;
            E_FALL      <= eFallNext;
            STRETCH     <= stretchNext;
            CORE_nRESET <= coreNext;
        end
    end

    assign PHASE = phase;

endmodule

// File: tb/tb_hd6309_clkgen.sv
// Bench for hd6309_clkgen: a default instance and a QUARTER=3 instance, checked against
// directed expectations and a quarter-level reference model.
module tb_hd6309_clkgen;

    logic CLK4 = 1'b0;
    always #5 CLK4 = ~CLK4;

    logic nRESET = 1'b0, MRDY = 1'b1, nRESET3 = 1'b0, MRDY3 = 1'b1;
    logic E, Q, E_RISE, E_FALL, STRETCH, CORE_nRESET;
    logic E3, Q3, E_RISE3, E_FALL3, STRETCH3, CORE_nRESET3;
    logic [1:0] PHASE, PHASE3;

    hd6309_clkgen dut (
        .CLK4(CLK4), .nRESET(nRESET), .MRDY(MRDY), .E(E), .Q(Q), .PHASE(PHASE),
        .E_RISE(E_RISE), .E_FALL(E_FALL), .STRETCH(STRETCH), .CORE_nRESET(CORE_nRESET)
    );

    hd6309_clkgen #(.QUARTER(3), .RST_CYCLES(2), .MAX_STRETCH(2)) dut3 (
        .CLK4(CLK4), .nRESET(nRESET3), .MRDY(MRDY3), .E(E3), .Q(Q3), .PHASE(PHASE3),
        .E_RISE(E_RISE3), .E_FALL(E_FALL3), .STRETCH(STRETCH3), .CORE_nRESET(CORE_nRESET3)
    );

    int checks = 0;
    int errors = 0;
    bit chkEn  = 1'b0;

    // Reference model: quarters of QP cycles, stretch budget SP, reset held for RP E cycles.
    int QP[2] = '{1, 3};
    int RP[2] = '{1, 2};
    int SP[2] = '{8, 2};
    int mCyc[2], mPh[2], mSc[2], mEnt[2];
    bit mSt[2], mCore[2], mRise[2], mFall[2];

    task automatic model_step(input int k, input bit nr, input bit rdy);
        int np;
        if (!nr) begin
            mCyc[k] = 0; mPh[k] = 3; mSc[k] = 0; mEnt[k] = 0;
            mSt[k] = 0; mCore[k] = 0; mRise[k] = 0; mFall[k] = 0;
        end else begin
            bit endOfQuarter;
            endOfQuarter = ((mCyc[k] % QP[k]) == QP[k] - 1);
            mCyc[k]++;
            mRise[k] = 0;
            mFall[k] = 0;
            if (endOfQuarter) begin
                if (mPh[k] == 1 && !rdy && mSc[k] < SP[k]) begin
                    mSc[k]++;
                    mSt[k] = 1;
                end else begin
                    mSt[k] = 0;
                    mSc[k] = 0;
                    np = (mPh[k] + 1) % 4;
                    mRise[k] = (np == 0);
                    mFall[k] = (np == 2);
                    if (np == 3 && !mCore[k]) begin
                        mEnt[k]++;
                        if (mEnt[k] == RP[k]) mCore[k] = 1;
                    end
                    mPh[k] = np;
                end
            end
        end
    endtask

    always @(posedge CLK4) begin
        model_step(0, nRESET, MRDY);
        model_step(1, nRESET3, MRDY3);
    end

    function automatic logic [7:0] model_vec(input int k);
        logic [1:0] p;
        p = 2'(mPh[k]);
        return {p < 2'd2, (p == 2'd1) || (p == 2'd2), p, mRise[k], mFall[k], mSt[k], mCore[k]};
    endfunction

    always @(negedge CLK4) begin
        if (chkEn) begin
            checks++;
            if ({E, Q, PHASE, E_RISE, E_FALL, STRETCH, CORE_nRESET} !== model_vec(0)) begin
                errors++;
                $display("FAIL model_q1 t=%0t got %b exp %b", $time,
                         {E, Q, PHASE, E_RISE, E_FALL, STRETCH, CORE_nRESET}, model_vec(0));
            end
            checks++;
            if ({E3, Q3, PHASE3, E_RISE3, E_FALL3, STRETCH3, CORE_nRESET3} !== model_vec(1)) begin
                errors++;
                $display("FAIL model_q3 t=%0t got %b exp %b", $time,
                         {E3, Q3, PHASE3, E_RISE3, E_FALL3, STRETCH3, CORE_nRESET3}, model_vec(1));
            end
        end
    end

    task automatic test_reset;
        nRESET = 0; nRESET3 = 0; MRDY = 1; MRDY3 = 1;
        repeat (3) @(negedge CLK4);
        chkEn = 1'b1;
        checks++;
        if ({E, Q, PHASE, E_RISE, E_FALL, STRETCH, CORE_nRESET} !== 8'b0011_0000) begin
            errors++;
            $display("FAIL reset_q1 got %b exp 00110000", {E, Q, PHASE, E_RISE, E_FALL, STRETCH, CORE_nRESET});
        end
        checks++;
        if ({E3, Q3, PHASE3, E_RISE3, E_FALL3, STRETCH3, CORE_nRESET3} !== 8'b0011_0000) begin
            errors++;
            $display("FAIL reset_q3 got %b exp 00110000", {E3, Q3, PHASE3, E_RISE3, E_FALL3, STRETCH3, CORE_nRESET3});
        end
    endtask

    task automatic test_defaults;
        int p;
        nRESET = 1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK4);
            p = (i - 1) % 4;
            checks++;
            if ({E, Q} !== {p < 2, (p == 1) || (p == 2)}) begin
                errors++;
                $display("FAIL defaults_eq edge %0d got %b exp %b", i, {E, Q}, {p < 2, (p == 1) || (p == 2)});
            end
            checks++;
            if (E_RISE !== (i % 4 == 1)) begin
                errors++;
                $display("FAIL defaults_erise edge %0d got %b exp %b", i, E_RISE, (i % 4 == 1));
            end
            checks++;
            if (CORE_nRESET !== (i >= 4)) begin
                errors++;
                $display("FAIL defaults_core edge %0d got %b exp %b", i, CORE_nRESET, (i >= 4));
            end
        end
    endtask

    task automatic test_quarter3;
        logic e[0:40], q[0:40], r[0:40], f[0:40], c[0:40];
        int tRise, tQ, hi, lo, badPulse;
        nRESET3 = 0; MRDY3 = 1;
        repeat (2) @(negedge CLK4);
        e[0] = E3; q[0] = Q3; r[0] = E_RISE3; f[0] = E_FALL3; c[0] = CORE_nRESET3;
        nRESET3 = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK4);
            e[i] = E3; q[i] = Q3; r[i] = E_RISE3; f[i] = E_FALL3; c[i] = CORE_nRESET3;
        end
        tRise = -1; tQ = -1; badPulse = 0;
        for (int i = 1; i <= 40; i++) begin
            if (tRise < 0 && e[i]) tRise = i;
            if (tQ < 0 && q[i]) tQ = i;
            if (r[i] !== (e[i] && !e[i-1])) badPulse++;
            if (f[i] !== (!e[i] && e[i-1])) badPulse++;
        end
        checks++;
        if (tRise != 3) begin errors++; $display("FAIL q3_first_rise got %0d exp 3", tRise); end
        checks++;
        if (tQ - tRise != 3) begin errors++; $display("FAIL q3_q_lag got %0d exp 3", tQ - tRise); end
        hi = 0; lo = 0;
        if (tRise > 0) begin
            for (int i = tRise; i <= 40 && e[i]; i++) hi++;
            for (int i = tRise + hi; i <= 40 && !e[i]; i++) lo++;
        end
        checks++;
        if (hi != 6 || lo != 6) begin errors++; $display("FAIL q3_duty got hi %0d lo %0d exp 6/6", hi, lo); end
        checks++;
        if (c[23] !== 1'b0 || c[24] !== 1'b1) begin
            errors++;
            $display("FAIL q3_core_release got c23=%b c24=%b exp 0/1", c[23], c[24]);
        end
        checks++;
        if (badPulse != 0) begin errors++; $display("FAIL q3_edge_pulses got %0d bad exp 0", badPulse); end
    endtask

    task automatic test_stretch;
        logic se[0:12], sq[0:12];
        int st, hi, tEf, tQf, guard;
        MRDY = 1;
        guard = 0;
        while (PHASE !== 2'd0 && guard < 8) begin @(negedge CLK4); guard++; end
        checks++;
        if (PHASE !== 2'd0) begin errors++; $display("FAIL stretch_wait got phase %0d exp 0", PHASE); end
        MRDY = 0;
        se[0] = E; sq[0] = Q; st = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge CLK4);
            se[i] = E; sq[i] = Q; st += int'(STRETCH);
            if (i == 4) MRDY = 1;
        end
        hi = 0;
        for (int i = 0; i <= 12 && se[i]; i++) hi++;
        tEf = hi;
        tQf = -1;
        for (int i = tEf; i <= 12; i++) if (tQf < 0 && !sq[i]) tQf = i;
        checks++;
        if (hi != 5) begin errors++; $display("FAIL stretch_e_high got %0d exp 5", hi); end
        checks++;
        if (st != 3) begin errors++; $display("FAIL stretch_count got %0d exp 3", st); end
        checks++;
        if (tQf - tEf != 1) begin errors++; $display("FAIL stretch_q_fall got %0d exp 1", tQf - tEf); end
    endtask

    task automatic test_perm_low;
        logic se[0:24], sr[0:24];
        logic [1:0] sp[0:24];
        int hi, lo, stalls, guard, tNext;
        MRDY = 0;
        guard = 0;
        do begin @(negedge CLK4); guard++; end while (E_RISE !== 1'b1 && guard < 30);
        se[0] = E; sr[0] = E_RISE; sp[0] = PHASE;
        for (int i = 1; i <= 24; i++) begin
            @(negedge CLK4);
            se[i] = E; sr[i] = E_RISE; sp[i] = PHASE;
        end
        hi = 0; lo = 0; stalls = 0; tNext = -1;
        for (int i = 0; i <= 24 && se[i]; i++) hi++;
        for (int i = hi; i <= 24 && !se[i]; i++) lo++;
        for (int i = 1; i <= 24; i++) begin
            if (sp[i] == sp[i-1] && sp[i] != 2'd1) stalls++;
            if (tNext < 0 && sr[i]) tNext = i;
        end
        checks++;
        if (hi != 10 || lo != 2) begin errors++; $display("FAIL permlow_duty got hi %0d lo %0d exp 10/2", hi, lo); end
        checks++;
        if (tNext != 12) begin errors++; $display("FAIL permlow_period got %0d exp 12", tNext); end
        checks++;
        if (stalls != 0) begin errors++; $display("FAIL permlow_stall got %0d exp 0", stalls); end
        MRDY = 1;
    endtask

    task automatic test_other_phases;
        int st, lastRise, badGap, rises;
        MRDY = 1;
        repeat (12) @(negedge CLK4);
        st = 0; lastRise = -1; badGap = 0; rises = 0;
        for (int i = 0; i < 32; i++) begin
            MRDY = (PHASE == 2'd1) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge CLK4);
            st += int'(STRETCH);
            if (E_RISE) begin
                if (lastRise >= 0 && i - lastRise != 4) badGap++;
                lastRise = i;
                rises++;
            end
        end
        MRDY = 1;
        checks++;
        if (st != 0) begin errors++; $display("FAIL other_phases_stretch got %0d exp 0", st); end
        checks++;
        if (badGap != 0 || rises < 7) begin
            errors++;
            $display("FAIL other_phases_period got badgaps %0d rises %0d exp 0 and >=7", badGap, rises);
        end
    endtask

    task automatic test_reset_mid_stretch;
        int stc, guard, p;
        MRDY = 0;
        guard = 0;
        do begin @(negedge CLK4); guard++; end while (E_RISE !== 1'b1 && guard < 30);
        stc = 0;
        while (stc < 4 && guard < 60) begin
            @(negedge CLK4); guard++;
            if (STRETCH) stc++;
        end
        checks++;
        if (stc != 4) begin errors++; $display("FAIL midstretch_reach got %0d exp 4", stc); end
        nRESET = 0;
        @(negedge CLK4);
        checks++;
        if ({E, Q, PHASE, STRETCH, CORE_nRESET} !== 6'b001100) begin
            errors++;
            $display("FAIL midstretch_reset got %b exp 001100", {E, Q, PHASE, STRETCH, CORE_nRESET});
        end
        MRDY = 1;
        @(negedge CLK4);
        nRESET = 1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge CLK4);
            p = (i - 1) % 4;
            checks++;
            if ({E, Q, CORE_nRESET} !== {p < 2, (p == 1) || (p == 2), i >= 4}) begin
                errors++;
                $display("FAIL midstretch_restart edge %0d got %b exp %b", i, {E, Q, CORE_nRESET},
                         {p < 2, (p == 1) || (p == 2), i >= 4});
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            nRESET  = ($urandom_range(0, 299) != 0);
            nRESET3 = ($urandom_range(0, 299) != 0);
            MRDY    = ($urandom_range(0, 2) != 0);
            MRDY3   = ($urandom_range(0, 2) != 0);
            @(negedge CLK4);
            checks++;
            if ((STRETCH && PHASE != 2'd1) || (STRETCH3 && PHASE3 != 2'd1)) begin
                errors++;
                $display("FAIL random_stretch_phase got %b/%0d %b/%0d exp phase 1", STRETCH, PHASE, STRETCH3, PHASE3);
            end
        end
        nRESET = 1; nRESET3 = 1; MRDY = 1; MRDY3 = 1;
        repeat (4) @(negedge CLK4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_defaults;
        test_quarter3;
        test_stretch;
        test_perm_low;
        test_other_phases;
        test_reset_mid_stretch;
        test_random;
        chkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
